otter_alu_mc: RTL and testbench
===============================

Name: otter_alu_mc

Overview:
- Parametrised multi-cycle ALU for the Otter core.
- Executes every base integer ALU function plus the RV32M multiply/divide/remainder group behind one valid/ready handshake.
- Base ops complete in 1 cycle. M ops use an iterative shift-add multiplier / restoring divider with fixed latency.
- Sits in the execute stage; the control FSM stalls on in_ready low.

Parameters:
- XLEN, 32, operand/result width; must be ≥8 and a power of two.
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden).
- ILLEGAL_VAL, 32'hDEADDEAD (zero-extended/truncated to XLEN), result for undefined base op codes.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  request valid; accepted when start & in_ready.
- kill  in  1  synchronous abort of any in-flight op.
- op  in  5  op[4]=0: base function code in op[3:0]; op[4]=1: M op, funct3 in op[2:0], op[3] ignored.
- srcA  in  XLEN  operand A.
- srcB  in  XLEN  operand B.
- in_ready  out  1  high only in IDLE.
- busy  out  1  high in CALC and FIX.
- result_valid  out  1  one-cycle pulse, high only in DONE.
- result  out  XLEN  registered result; holds last value until the next DONE.

Behaviour:
- Reset (RST_N low, async): state=IDLE, result=0, result_valid=0, busy=0, in_ready=1 once the state is IDLE. Reset mid-operation discards the operation with no result_valid.
- Acceptance: op, srcA and srcB are latched at the accepting edge. Input changes afterwards are ignored. start while not in_ready is ignored, not queued.
- Base codes:
  - 0000 ADD, 1000 SUB (mod 2^XLEN).
  - 0110 OR, 0111 AND, 0100 XOR.
  - 0001 SLL, 0101 SRL, 1101 SRA; each uses srcB[SHW-1:0] and sign-fills for SRA.
  - 0010 SLT signed, 0011 SLTU unsigned; each yields 0/1.
  - 1001 COPY (result=srcA).
  - Any other code yields ILLEGAL_VAL.
- M funct3:
  - 000 MUL (low XLEN).
  - 001 MULH s×s, 010 MULHSU s×u, 011 MULHU u×u (each returns the high XLEN).
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States: IDLE, CALC, FIX, DONE.
  - IDLE: accept a base op → DONE, result computed at that edge. Accept an M op → CALC, cnt=XLEN-1, operands converted to magnitudes, signs recorded.
  - CALC: one multiply or divide step per cycle. cnt==0 → FIX, else cnt-1.
  - FIX: apply sign correction and special cases, write result → DONE.
  - DONE: result_valid=1 → IDLE.
- Latency, measured from the accept cycle k:
  - Base op: result_valid in cycle k+1.
  - M op: result_valid in cycle k+XLEN+2 (34 for XLEN=32).
  - No early-out; latency is data-independent.
- Multiply: unsigned 2·XLEN product of magnitudes, negated in FIX if the operand signs differ for signed variants.
- Divide: restoring division on magnitudes.
  - Quotient sign is signA^signB.
  - Remainder sign follows the dividend.
- Divide special cases, resolved in FIX:
  - Divisor 0: quotient = all ones; remainder = srcA.
  - Signed DIV/REM with srcA=−2^(XLEN-1) and srcB=−1: quotient = srcA; remainder = 0.
- kill:
  - Any state → IDLE at the next edge. result_valid is not raised and result is unchanged.
  - kill and start in the same cycle: kill wins and nothing is accepted.
  - kill in DONE: the current cycle's pulse still shows (already registered) and the FSM returns to IDLE.
- Back-to-back: start may be asserted in the cycle after DONE (IDLE). Minimum base-op throughput is 1 op per 2 cycles.

Test Plan:
- Reset, then ADD srcA=32'h7FFFFFFF, srcB=1 → result_valid in cycle k+1, result=32'h80000000. SRA srcA=32'h80000000, srcB=4 → 32'hF8000000. op=5'b01111 → 32'hDEADDEAD.
- MULH srcA=32'hFFFFFFFF (−1), srcB=2 → 32'hFFFFFFFF. MULHU same operands → 32'h00000001. MUL → 32'hFFFFFFFE. result_valid exactly at k+34, busy high for cycles k+1..k+33.
- DIV −7/2 → 32'hFFFFFFFD, REM −7/2 → 32'hFFFFFFFF. DIVU 7/0 → 32'hFFFFFFFF. REMU 7/0 → 7. DIV 32'h80000000/32'hFFFFFFFF → 32'h80000000, REM of the same operands → 0.
- Start a DIV, toggle srcA/srcB and pulse start during CALC → the inputs are ignored, in_ready stays low and the original quotient is returned.
- Pulse kill at cycle k+10 of a MUL → no result_valid, result retains its prior value, in_ready high at k+11. Assert RST_N low mid-DIV → immediate IDLE, result=0.
- Re-run with XLEN=16: MULHU 16'hFFFF×16'hFFFF → 16'hFFFE with latency 18. A shift by srcB=17 uses 4 bits (shift 1).

Source files
------------

// File: rtl/otter_alu_mc.sv
// Multi-cycle Otter ALU: single-cycle base integer ops plus RV32M multiply/divide
// via an iterative shift-add multiplier and restoring divider (XLEN must be a power of two >= 8).
module otter_alu_mc #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] ILLEGAL_VAL = 32'hDEADDEAD
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            start,
  input  logic            kill,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            in_ready,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ILLEGAL_X = XLEN'(ILLEGAL_VAL);
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Handshake: a request is taken on a rising edge where start & in_ready & !kill.
  // result_valid is a single-cycle pulse; result holds until the next pulse.
  state_t            r_state;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_valid;
  logic [XLEN-1:0]   r_result;
  logic [SHW-1:0]    r_cnt;
  logic [2:0]        r_f3;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_mq;
  logic              r_neg_res;
  logic              r_sign_a;

  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_base_res;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_shift_rem;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [XLEN-1:0]   w_step_acc;
  logic [XLEN-1:0]   w_step_mq;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_fix_res;

  assign in_ready     = r_in_ready;
  assign busy         = r_busy;
  assign result_valid = r_valid;
  assign result       = r_result;
  assign dbg_state    = r_state;

  assign w_shamt = srcB[SHW-1:0];

  always_comb begin
    w_base_res = ILLEGAL_X;
    case (op[3:0])
      4'b0000: w_base_res = srcA + srcB;
      4'b1000: w_base_res = srcA - srcB;
      4'b0110: w_base_res = srcA | srcB;
      4'b0111: w_base_res = srcA & srcB;
      4'b0100: w_base_res = srcA ^ srcB;
      4'b0001: w_base_res = srcA << w_shamt;
      4'b0101: w_base_res = srcA >> w_shamt;
      4'b1101: w_base_res = $signed(srcA) >>> w_shamt;
      4'b0010: w_base_res = XLEN'($signed(srcA) < $signed(srcB));
      4'b0011: w_base_res = XLEN'(srcA < srcB);
      4'b1001: w_base_res = srcA;
      default: w_base_res = ILLEGAL_X;
    endcase
  end

  // Signedness per funct3: MULH/DIV/REM sign both, MULHSU only A; MUL needs no sign handling.
  assign w_a_signed = (op[2:0] == 3'b001) || (op[2:0] == 3'b010) ||
                      (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
  assign w_b_signed = (op[2:0] == 3'b001) || (op[2:0] == 3'b100) ||
                      (op[2:0] == 3'b110);
  assign w_sa    = w_a_signed & srcA[XLEN-1];
  assign w_sb    = w_b_signed & srcB[XLEN-1];
  assign w_mag_a = w_sa ? (-srcA) : srcA;
  assign w_mag_b = w_sb ? (-srcB) : srcB;

  // Multiply step: add multiplicand on LSB of multiplier, shift {acc,mq} right.
  assign w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});

  // Restoring divide step: shift next dividend bit into the partial remainder.
  assign w_shift_rem = {r_acc, r_mq[XLEN-1]};
  assign w_ge        = (w_shift_rem >= {1'b0, r_mcand});
  assign w_diff      = w_shift_rem[XLEN-1:0] - r_mcand;

  always_comb begin
    w_step_acc = r_acc;
    w_step_mq  = r_mq;
    if (r_f3[2]) begin
      w_step_acc = w_ge ? w_diff : w_shift_rem[XLEN-1:0];
      w_step_mq  = {r_mq[XLEN-2:0], w_ge};
    end else begin
      w_step_acc = w_mul_sum[XLEN:1];
      w_step_mq  = {w_mul_sum[0], r_mq[XLEN-1:1]};
    end
  end

  assign w_prod   = {r_acc, r_mq};
  assign w_prod_s = r_neg_res ? (-w_prod) : w_prod;
  assign w_quo    = r_neg_res ? (-r_mq) : r_mq;
  assign w_rem    = r_sign_a ? (-r_acc) : r_acc;
  assign w_div0   = (r_b == '0);
  assign w_ovf    = (r_a == MIN_NEG) && (r_b == {XLEN{1'b1}});

  always_comb begin
    w_fix_res = '0;
    case (r_f3)
      3'b000:  w_fix_res = w_prod_s[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      3'b100:  w_fix_res = w_div0 ? {XLEN{1'b1}} : (w_ovf ? r_a : w_quo);
      3'b101:  w_fix_res = w_div0 ? {XLEN{1'b1}} : r_mq;
      3'b110:  w_fix_res = w_div0 ? r_a : (w_ovf ? '0 : w_rem);
      default: w_fix_res = w_div0 ? r_a : r_acc;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_cnt      <= '0;
      r_f3       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_mcand    <= '0;
      r_acc      <= '0;
      r_mq       <= '0;
      r_neg_res  <= 1'b0;
      r_sign_a   <= 1'b0;
    end else if (kill) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_in_ready <= 1'b0;
            if (op[4]) begin
              r_state   <= S_CALC;
              r_busy    <= 1'b1;
              r_cnt     <= SHW'(XLEN-1);
              r_f3      <= op[2:0];
              r_a       <= srcA;
              r_b       <= srcB;
              r_mcand   <= w_mag_b;
              r_acc     <= '0;
              r_mq      <= w_mag_a;
              r_neg_res <= w_sa ^ w_sb;
              r_sign_a  <= w_sa;
            end else begin
              r_state  <= S_DONE;
              r_valid  <= 1'b1;
              r_result <= w_base_res;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_step_acc;
          r_mq  <= w_step_mq;
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          r_state  <= S_DONE;
          r_busy   <= 1'b0;
          r_valid  <= 1'b1;
          r_result <= w_fix_res;
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_valid    <= 1'b0;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otter_alu_mc.sv
// Bench for otter_alu_mc: a 32-bit and a 16-bit instance driven with directed and
// random ops, checked against a plain-arithmetic reference model through expected queues.
module tb_otter_alu_mc;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic RST_N;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- DUT signals ----------------
  logic         start, kill;
  logic [4:0]   op;
  logic [W-1:0] srcA, srcB;
  logic         in_ready, busy, result_valid;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  logic         start16, kill16;
  logic [4:0]   op16;
  logic [15:0]  a16, b16;
  logic         ir16, busy16, rv16;
  logic [15:0]  res16;
  logic [1:0]   dbg16;

  otter_alu_mc #(.XLEN(32)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .kill(kill), .op(op),
    .srcA(srcA), .srcB(srcB), .in_ready(in_ready), .busy(busy),
    .result_valid(result_valid), .result(result), .dbg_state(dbg_state)
  );

  otter_alu_mc #(.XLEN(16)) u_dut16 (
    .CLK(CLK), .RST_N(RST_N), .start(start16), .kill(kill16), .op(op16),
    .srcA(a16), .srcB(b16), .in_ready(ir16), .busy(busy16),
    .result_valid(rv16), .result(res16), .dbg_state(dbg16)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  logic [W-1:0] exp16_q[$];
  int           lat16_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_model(input logic [4:0] f, input logic [31:0] a,
                                             input logic [31:0] b, input int w);
    logic [63:0] mask, ua, ub, r;
    longint      sa, sb, min_v;
    int          sh;
    mask  = (w == 32) ? 64'hFFFF_FFFF : 64'hFFFF;
    ua    = {32'b0, a} & mask;
    ub    = {32'b0, b} & mask;
    sa    = (w == 32) ? longint'($signed(a)) : longint'($signed(a[15:0]));
    sb    = (w == 32) ? longint'($signed(b)) : longint'($signed(b[15:0]));
    min_v = -(longint'(1) <<< (w - 1));
    sh    = int'(ub % 64'(w));
    r     = 64'hDEAD_DEAD;
    if (!f[4]) begin
      case (f[3:0])
        4'b0000: r = ua + ub;
        4'b1000: r = ua - ub;
        4'b0110: r = ua | ub;
        4'b0111: r = ua & ub;
        4'b0100: r = ua ^ ub;
        4'b0001: r = ua << sh;
        4'b0101: r = ua >> sh;
        4'b1101: r = 64'(sa >>> sh);
        4'b0010: r = (sa < sb) ? 64'd1 : 64'd0;
        4'b0011: r = (ua < ub) ? 64'd1 : 64'd0;
        4'b1001: r = ua;
        default: r = 64'hDEAD_DEAD;
      endcase
    end else begin
      case (f[2:0])
        3'd0: r = ua * ub;
        3'd1: r = 64'((sa * sb) >>> w);
        3'd2: r = 64'((sa * longint'(ub)) >>> w);
        3'd3: r = (ua * ub) >> w;
        3'd4: r = (ub == 0) ? mask : ((sa == min_v && sb == -1) ? ua : 64'(sa / sb));
        3'd5: r = (ub == 0) ? mask : ua / ub;
        3'd6: r = (ub == 0) ? ua : ((sa == min_v && sb == -1) ? 64'd0 : 64'(sa % sb));
        default: r = (ub == 0) ? ua : ua % ub;
      endcase
    end
    return W'(r & mask);
  endfunction

  function automatic logic [4:0] rand_op();
    logic [3:0] codes [0:10];
    codes = '{4'b0000, 4'b1000, 4'b0110, 4'b0111, 4'b0100, 4'b0001,
              4'b0101, 4'b1101, 4'b0010, 4'b0011, 4'b1001};
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return {1'b1, 4'($urandom)};
      4:          return {1'b0, 4'($urandom)};
      default:    return {1'b0, codes[$urandom_range(0, 10)]};
    endcase
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All driving happens 2 time units after a rising edge.
  task automatic issue(input logic [4:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int g = 0;
    while (!in_ready && g < 100) begin
      @(posedge CLK); #2;
      g++;
    end
    if (g >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    start = 1'b1; op = f; srcA = a; srcB = b;
    exp_q.push_back(ref_model(f, a, b, 32));
    lat_q.push_back(f[4] ? W + 2 : 1);
    @(posedge CLK); #2;
    start = 1'b0; op = 5'($urandom); srcA = $urandom; srcB = $urandom;
  endtask

  task automatic issue16(input logic [4:0] f, input logic [15:0] a, input logic [15:0] b);
    int g = 0;
    while (!ir16 && g < 100) begin
      @(posedge CLK); #2;
      g++;
    end
    if (g >= 100) chk("in_ready16_timeout", 32'(ir16), 32'd1);
    start16 = 1'b1; op16 = f; a16 = a; b16 = b;
    exp16_q.push_back(ref_model(f, {16'b0, a}, {16'b0, b}, 16));
    lat16_q.push_back(f[4] ? 16 + 2 : 1);
    @(posedge CLK); #2;
    start16 = 1'b0; op16 = 5'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK); #2;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic         out_q = 1'b0, out16 = 1'b0;
  int           acc_cyc = 0, cur_lat = 1, acc16 = 0, lat16 = 1;
  logic [W-1:0] model_last = '0;

  always @(negedge CLK) begin
    logic         prev, prev16, ev, ev16;
    int           d, d16;
    logic [W-1:0] e;
    cyc++;
    if (!RST_N) begin
      if (out_q) void'(exp_q.pop_front());
      if (out16) void'(exp16_q.pop_front());
      out_q = 1'b0; out16 = 1'b0;
      model_last = '0;
    end
    prev = out_q;
    d    = cyc - acc_cyc;
    ev   = prev && (d == cur_lat);
    chk("in_ready", 32'(in_ready), 32'(!prev));
    chk("busy", 32'(busy), 32'(prev && cur_lat > 1 && d < cur_lat));
    chk("result_valid", 32'(result_valid), 32'(ev));
    if (ev) begin
      e = exp_q.pop_front();
      chk("result", result, e);
      model_last = e;
      out_q = 1'b0;
    end else begin
      chk("result_hold", result, model_last);
    end
    if (RST_N && kill && prev && !ev) begin
      void'(exp_q.pop_front());
      out_q = 1'b0;
    end
    if (RST_N && start && !kill && !prev) begin
      if (lat_q.size() == 0) begin
        chk("accept_without_request", 32'd1, 32'd0);
      end else begin
        cur_lat = lat_q.pop_front();
        acc_cyc = cyc;
        out_q   = 1'b1;
      end
    end

    prev16 = out16;
    d16    = cyc - acc16;
    ev16   = prev16 && (d16 == lat16);
    chk("in_ready16", 32'(ir16), 32'(!prev16));
    chk("busy16", 32'(busy16), 32'(prev16 && lat16 > 1 && d16 < lat16));
    chk("result_valid16", 32'(rv16), 32'(ev16));
    if (ev16) begin
      chk("result16", {16'b0, res16}, exp16_q.pop_front());
      out16 = 1'b0;
    end
    if (RST_N && start16 && !prev16 && lat16_q.size() != 0) begin
      lat16 = lat16_q.pop_front();
      acc16 = cyc;
      out16 = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int g;
    RST_N = 1'b0; start = 1'b0; kill = 1'b0; op = '0; srcA = '0; srcB = '0;
    start16 = 1'b0; kill16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    cycles(3);
    RST_N = 1'b1;
    cycles(2);

    // directed base and M vectors
    issue(5'b00000, 32'h7FFF_FFFF, 32'h1);
    issue(5'b01101, 32'h8000_0000, 32'h4);
    issue(5'b01111, 32'h1234_5678, 32'h9);
    issue(5'b00001, 32'h1, 32'd33);
    issue(5'b00010, 32'hFFFF_FFFF, 32'h1);
    issue(5'b00011, 32'hFFFF_FFFF, 32'h1);
    issue(5'b10001, 32'hFFFF_FFFF, 32'h2);
    issue(5'b10011, 32'hFFFF_FFFF, 32'h2);
    issue(5'b10000, 32'hFFFF_FFFF, 32'h2);
    issue(5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(5'b10100, 32'hFFFF_FFF9, 32'h2);
    issue(5'b10110, 32'hFFFF_FFF9, 32'h2);
    issue(5'b10101, 32'h7, 32'h0);
    issue(5'b10111, 32'h7, 32'h0);
    issue(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(5'b11100, 32'hFFFF_FFF9, 32'h0);

    // start pulses and input changes during CALC must be ignored
    issue(5'b10100, 32'd1000, 32'd7);
    cycles(3);
    start = 1'b1; op = 5'b00000; srcA = 32'h5; srcB = 32'h6;
    cycles(4);
    start = 1'b0;

    // kill at k+10 of a MUL: dropped, result held
    issue(5'b10000, 32'h0001_2345, 32'h0000_0777);
    cycles(9);
    kill = 1'b1;
    cycles(1);
    kill = 1'b0;
    cycles(2);

    // kill with start in IDLE: nothing accepted
    start = 1'b1; kill = 1'b1; op = 5'b00000; srcA = 32'h11; srcB = 32'h22;
    cycles(1);
    start = 1'b0; kill = 1'b0;
    cycles(2);

    // kill in DONE: pulse still visible
    issue(5'b01000, 32'h10, 32'h3);
    kill = 1'b1;
    cycles(1);
    kill = 1'b0;

    // back-to-back base ops
    issue(5'b00110, 32'hF0F0_0000, 32'h0000_0F0F);
    issue(5'b00100, 32'hAAAA_5555, 32'hFFFF_0000);

    // reset mid-DIV
    issue(5'b10100, 32'd12345, 32'd17);
    cycles(5);
    RST_N = 1'b0;
    cycles(2);
    RST_N = 1'b1;
    cycles(2);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      issue(rand_op(), rand_val(), rand_val());
    end

    // 16-bit instance
    issue16(5'b10011, 16'hFFFF, 16'hFFFF);
    issue16(5'b00001, 16'h0001, 16'd17);
    issue16(5'b01101, 16'h8000, 16'd3);
    issue16(5'b10100, 16'h8000, 16'hFFFF);
    issue16(5'b01010, 16'h1, 16'h1);
    for (int i = 0; i < 30; i++) begin
      issue16(rand_op(), 16'(rand_val()), 16'(rand_val()));
    end

    g = 0;
    while ((out_q || out16 || exp_q.size() != 0 || exp16_q.size() != 0) && g < 200) begin
      cycles(1);
      g++;
    end
    if (g >= 200) chk("drain_timeout", 32'(exp_q.size() + exp16_q.size()), 32'd0);
    cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
